// File: rtl/jtframe_dwnld_pkg.sv
// Shared definitions for the download bridge: controller states and FIFO entry layout.
// A FIFO entry is packed as {ba[1:0], word[SDRAMW-1:0], lsb, byte[7:0]}.
package jtframe_dwnld_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } dwnld_state_e;

  // bank (2) + byte lane (1) + data byte (8) on top of the word address
  localparam int ENTRY_EXTRA = 11;

  function automatic int entry_width(input int sdramw);
    return sdramw + ENTRY_EXTRA;
  endfunction

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Small byte FIFO between the ioctl side and the SDRAM write sequencer.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module jtframe_dwnld_fifo #(
  parameter int DW = 33,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] dout
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at 2^AW
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jtframe_dwnld_bridge.sv
// Bridges the byte-wide ioctl download stream onto jtframe_sdram64 programming writes.
// Each byte becomes one masked 16-bit SDRAM write; bytes are buffered in a small FIFO.
// Optional macro JTFRAME_DWNLD_HEADER_EN: skip the first HEADER bytes of every session
// and rebase the addresses of the remaining bytes by HEADER.
module jtframe_dwnld_bridge
  import jtframe_dwnld_pkg::*;
#(
  parameter int SDRAMW = 22,
  parameter int FIFOW  = 2,
  parameter int HEADER = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic [25:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic [1:0]        prog_ba,
  output logic              prog_we,
  input  logic              prog_ack,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              ovf
);

  localparam int EW = entry_width(SDRAMW);

  dwnld_state_e  state;
  dwnld_state_e  state_nxt;
  logic [25:0]   addr;
  logic          in_header;
  logic          accept;
  logic          pop;
  logic          load;
  logic          we_nxt;
  logic          full;
  logic          empty;
  logic [EW-1:0] din;
  logic [EW-1:0] head;
  logic          unused_addr;

`ifdef JTFRAME_DWNLD_HEADER_EN
  logic [31:0] hdr_cnt;

  assign in_header = (hdr_cnt < 32'(HEADER));
  assign addr      = ioctl_addr - 26'(HEADER);

  // Count leading bytes of the session; re-arms whenever downloading is low
  always_ff @(posedge clk) begin
    if (rst || !downloading) hdr_cnt <= '0;
    else if (ioctl_wr && in_header) hdr_cnt <= hdr_cnt + 32'd1;
  end
`else
  logic [31:0] unused_header;

  assign in_header     = 1'b0;
  assign addr          = ioctl_addr;
  assign unused_header = 32'(HEADER);
`endif

  assign accept      = downloading & ioctl_wr & ~in_header;
  assign din         = {addr[SDRAMW+2:SDRAMW+1], addr[SDRAMW:1], addr[0], ioctl_dout};
  assign unused_addr = ^addr[25:SDRAMW+3];

  jtframe_dwnld_fifo #(
    .DW (EW),
    .AW (FIFOW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (din),
    .full  (full),
    .empty (empty),
    .dout  (head)
  );

  // Write sequencer: load the head entry, hold the request until ack, pop on rdy
  always_comb begin
    state_nxt = state;
    we_nxt    = prog_we;
    load      = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          load      = 1'b1;
          we_nxt    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (prog_ack) begin
          we_nxt = 1'b0;
          if (prog_rdy) begin
            pop       = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (prog_rdy) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        we_nxt    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered state, SDRAM request fields, sticky overflow and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_data  <= '0;
      prog_mask  <= 2'b11;
      prog_ba    <= '0;
      ovf        <= 1'b0;
      dwnld_busy <= 1'b0;
    end else begin
      state   <= state_nxt;
      prog_we <= we_nxt;
      if (load) begin
        prog_ba   <= head[EW-1:EW-2];
        prog_addr <= head[SDRAMW+8:9];
        prog_mask <= head[8] ? 2'b01 : 2'b10;
        prog_data <= {head[7:0], head[7:0]};
      end
      if (accept && full && !pop) ovf <= 1'b1;
      dwnld_busy <= downloading | ~empty | (state != IDLE);
    end
  end

endmodule

// File: tb/tb_jtframe_dwnld_bridge.sv
// Self-checking bench for jtframe_dwnld_bridge: directed cases plus randomized sessions
// against a queue-based model of the byte buffer and an SDRAM ack/rdy responder.
`timescale 1ns/1ps
module tb_jtframe_dwnld_bridge;

  localparam int SDRAMW = 22;
  localparam int FIFOW  = 2;
  localparam int DEPTH  = 4;
`ifdef JTFRAME_DWNLD_HEADER_EN
  localparam int HDR    = 16;
  localparam bit HDR_EN = 1'b1;
`else
  localparam int HDR    = 3;
  localparam bit HDR_EN = 1'b0;
`endif
  localparam int HOFF = HDR_EN ? HDR : 0;

  typedef struct {
    int unsigned ba;
    int unsigned word;
    int unsigned mask;
    int unsigned data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              downloading = 1'b0;
  logic [25:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_dout = '0;
  logic              ioctl_wr = 1'b0;
  logic [SDRAMW-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic [1:0]        prog_mask;
  logic [1:0]        prog_ba;
  logic              prog_we;
  logic              prog_ack = 1'b0;
  logic              prog_rdy = 1'b0;
  logic              dwnld_busy;
  logic              ovf;

  wr_t exp_q[$];
  wr_t wlog[$];
  bit  ovf_m = 1'b0;
  bit  busy_m = 1'b0;
  int  hcnt_m = 0;
  int  phase = 0;
  int  cnt = 0;
  int  idle_wait = 0;
  bit  just_popped = 1'b0;
  bit  rst_prev = 1'b1;
  bit  hold_ack = 1'b0;
  int  lat_min = 3;
  int  lat_max = 3;
  int  both_pct = 0;
  int  errors = 0;
  int  checks = 0;

  jtframe_dwnld_bridge #(
    .SDRAMW (SDRAMW),
    .FIFOW  (FIFOW),
    .HEADER (HDR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_ba     (prog_ba),
    .prog_we     (prog_we),
    .prog_ack    (prog_ack),
    .prog_rdy    (prog_rdy),
    .dwnld_busy  (dwnld_busy),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected SDRAM write for a byte, straight from the address-split rules
  function automatic wr_t make_entry(input logic [25:0] a, input logic [7:0] d);
    wr_t e;
    int unsigned ad;
    ad     = (int'(a) + 67108864 - HOFF) % 67108864;
    e.ba   = (ad >> (SDRAMW + 1)) % 4;
    e.word = (ad / 2) % (1 << SDRAMW);
    e.mask = (ad % 2 == 1) ? 1 : 2;
    e.data = int'(d) * 257;
    return e;
  endfunction

  task automatic cmpHead(input string tag);
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_unexpected_we"}, 64'(prog_we), 64'd0);
    end else begin
      checkOutput({tag, "_ba"},   64'(prog_ba),   64'(exp_q[0].ba));
      checkOutput({tag, "_addr"}, 64'(prog_addr), 64'(exp_q[0].word));
      checkOutput({tag, "_mask"}, 64'(prog_mask), 64'(exp_q[0].mask));
      checkOutput({tag, "_data"}, 64'(prog_data), 64'(exp_q[0].data));
    end
  endtask

  // Per-cycle compare, SDRAM responder and model update, all at the falling edge
  always @(negedge clk) begin
    bit pop_now;
    bit acc;
    bit room;
    wr_t act;
    pop_now = 1'b0;
    if (rst_prev) begin
      checkOutput("rst_we",   64'(prog_we),    64'd0);
      checkOutput("rst_addr", 64'(prog_addr),  64'd0);
      checkOutput("rst_data", 64'(prog_data),  64'd0);
      checkOutput("rst_mask", 64'(prog_mask),  64'd3);
      checkOutput("rst_ba",   64'(prog_ba),    64'd0);
      checkOutput("rst_ovf",  64'(ovf),        64'd0);
      checkOutput("rst_busy", 64'(dwnld_busy), 64'd0);
    end else begin
      checkOutput("ovf",  64'(ovf),        64'(ovf_m));
      checkOutput("busy", 64'(dwnld_busy), 64'(busy_m));
      if (phase == 0) begin
        if (just_popped) begin
          checkOutput("gap_we", 64'(prog_we), 64'd0);
        end else if (prog_we) begin
          cmpHead("req");
          act.ba = prog_ba; act.word = prog_addr; act.mask = prog_mask; act.data = prog_data;
          wlog.push_back(act);
          phase     = 1;
          cnt       = $urandom_range(lat_max, lat_min);
          idle_wait = 0;
        end else if (exp_q.size() > 0) begin
          if (idle_wait >= 1) checkOutput("req_latency", 64'(prog_we), 64'd1);
          idle_wait++;
        end else begin
          idle_wait = 0;
        end
      end else if (phase == 1) begin
        checkOutput("we_hold", 64'(prog_we), 64'd1);
        cmpHead("hold");
      end else begin
        checkOutput("we_after_ack", 64'(prog_we), 64'd0);
      end
    end

    prog_ack = 1'b0;
    prog_rdy = 1'b0;
    if (!rst) begin
      if (phase == 1 && !hold_ack) begin
        if (cnt > 0) cnt--;
        else begin
          prog_ack = 1'b1;
          if ($urandom_range(99, 0) < both_pct) begin
            prog_rdy = 1'b1;
            pop_now  = 1'b1;
            phase    = 0;
          end else begin
            phase = 2;
            cnt   = $urandom_range(lat_max, lat_min);
          end
        end
      end else if (phase == 2) begin
        if (cnt > 0) cnt--;
        else begin
          prog_rdy = 1'b1;
          pop_now  = 1'b1;
          phase    = 0;
        end
      end
    end

    if (rst) begin
      exp_q.delete();
      ovf_m       = 1'b0;
      busy_m      = 1'b0;
      hcnt_m      = 0;
      phase       = 0;
      idle_wait   = 0;
      just_popped = 1'b0;
      rst_prev    = 1'b1;
    end else begin
      rst_prev = 1'b0;
      busy_m   = downloading || (exp_q.size() > 0);
      acc      = 1'b0;
      if (downloading && ioctl_wr) begin
        if (HDR_EN && hcnt_m < HDR) hcnt_m++;
        else acc = 1'b1;
      end
      if (!downloading) hcnt_m = 0;
      room = (exp_q.size() < DEPTH) || pop_now;
      if (pop_now) void'(exp_q.pop_front());
      if (acc) begin
        if (room) exp_q.push_back(make_entry(ioctl_addr, ioctl_dout));
        else ovf_m = 1'b1;
      end
      just_popped = pop_now;
    end
  end

  // One ioctl byte strobe, then 'gap' quiet cycles; called at 1ns after a rising edge
  task automatic applyStimulus(input logic [25:0] a, input logic [7:0] d, input int gap);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic startSession();
    downloading = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < HOFF; i++) applyStimulus(26'(i), 8'hEE, 0);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || phase != 0 || dwnld_busy) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_timeout", 64'(n < 2000), 64'd1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int n0;
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("init_mask", 64'(prog_mask), 64'd3);
    checkOutput("init_we",   64'(prog_we),   64'd0);

    $display("[TB] two bytes, latency 3");
    wlog.delete();
    startSession();
    applyStimulus(26'(HOFF + 0), 8'h11, 0);
    applyStimulus(26'(HOFF + 1), 8'h22, 0);
    downloading = 1'b0;
    waitDrain();
    checkOutput("t037_count", 64'(wlog.size()), 64'd2);
    if (wlog.size() >= 2) begin
      checkOutput("t037_w0_addr", 64'(wlog[0].word), 64'd0);
      checkOutput("t037_w0_mask", 64'(wlog[0].mask), 64'h2);
      checkOutput("t037_w0_data", 64'(wlog[0].data), 64'h1111);
      checkOutput("t037_w1_addr", 64'(wlog[1].word), 64'd0);
      checkOutput("t037_w1_mask", 64'(wlog[1].mask), 64'h1);
      checkOutput("t037_w1_data", 64'(wlog[1].data), 64'h2222);
    end

    $display("[TB] bank split");
    wlog.delete();
    startSession();
    applyStimulus(26'(HOFF + 26'h0800002), 8'hA5, 0);
    downloading = 1'b0;
    waitDrain();
    checkOutput("t038_count", 64'(wlog.size()), 64'd1);
    if (wlog.size() >= 1) begin
      checkOutput("t038_ba",   64'(wlog[0].ba),   64'd1);
      checkOutput("t038_addr", 64'(wlog[0].word), 64'd1);
      checkOutput("t038_mask", 64'(wlog[0].mask), 64'h2);
      checkOutput("t038_data", 64'(wlog[0].data), 64'hA5A5);
    end

    $display("[TB] overflow with ack held");
    wlog.delete();
    hold_ack = 1'b1;
    startSession();
    for (int i = 0; i < 6; i++) applyStimulus(26'(HOFF + 40 + i), 8'(8'h30 + i), 0);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("t039_ovf",   64'(ovf),          64'd1);
    checkOutput("t039_model", 64'(exp_q.size()), 64'd4);
    downloading = 1'b0;
    hold_ack    = 1'b0;
    waitDrain();
    checkOutput("t039_writes", 64'(wlog.size()), 64'd4);
    checkOutput("t039_ovf_sticky", 64'(ovf), 64'd1);
    applyReset();
    checkOutput("t039_ovf_cleared", 64'(ovf), 64'd0);

    $display("[TB] downloading falls with bytes queued");
    wlog.delete();
    lat_min = 2; lat_max = 2;
    startSession();
    for (int i = 0; i < 3; i++) applyStimulus(26'(HOFF + 10 + i), 8'(8'h50 + i), 0);
    downloading = 1'b0;
    waitDrain();
    checkOutput("t040_writes", 64'(wlog.size()), 64'd3);
    checkOutput("t040_busy",   64'(dwnld_busy),  64'd0);

    $display("[TB] reset during request");
    hold_ack = 1'b1;
    startSession();
    applyStimulus(26'(HOFF + 4), 8'h77, 0);
    n = 0;
    while (phase != 1 && n < 20) begin @(posedge clk); #1; n++; end
    checkOutput("t042_req_seen", 64'(n < 20), 64'd1);
    n0 = wlog.size();
    applyReset();
    checkOutput("t042_we",   64'(prog_we),   64'd0);
    checkOutput("t042_mask", 64'(prog_mask), 64'd3);
    checkOutput("t042_addr", 64'(prog_addr), 64'd0);
    hold_ack = 1'b0;
    downloading = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    checkOutput("t042_nowrite", 64'(wlog.size()), 64'(n0));

`ifdef JTFRAME_DWNLD_HEADER_EN
    $display("[TB] header skip");
    wlog.delete();
    lat_min = 3; lat_max = 3;
    downloading = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) applyStimulus(26'(i), 8'(i), 15);
    downloading = 1'b0;
    waitDrain();
    checkOutput("t041_writes", 64'(wlog.size()), 64'd4);
    if (wlog.size() >= 1) begin
      checkOutput("t041_addr", 64'(wlog[0].word), 64'd0);
      checkOutput("t041_mask", 64'(wlog[0].mask), 64'h2);
      checkOutput("t041_data", 64'(wlog[0].data), 64'h1010);
    end
`endif

    $display("[TB] randomized sessions");
    lat_min = 0; lat_max = 4; both_pct = 30;
    for (int s = 0; s < 6; s++) begin
      startSession();
      n = $urandom_range(25, 5);
      for (int i = 0; i < n; i++)
        applyStimulus(26'($urandom), 8'($urandom), $urandom_range(4, 0));
      downloading = 1'b0;
      applyStimulus(26'($urandom), 8'($urandom), 1);
      if ($urandom_range(1, 0) == 1) waitDrain();
    end
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
